// File: rtl/adder_pipe_addsub.sv
// Pipelined add/subtract unit: the carry chain is cut into STAGES chunks with one register stage per chunk.
// A single global advance signal moves the whole pipe, so a stalled output freezes every stage, bubbles included.
module adder_pipe_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0]            carry_q, carry_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
  logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
  logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic [CHUNK:0]   part;

  assign adv      = !valid_q[STAGES-1] || out_ready;
  assign in_ready = adv;

  always_comb begin
    b_eff   = b ^ {WIDTH{sub}};
    valid_d = valid_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;

    // Stage 0 captures the operands with B already inverted for subtraction.
    valid_d[0] = in_valid;
    a_d[0]     = a;
    b_d[0]     = b_eff;
    sum_d[0]   = '0;
    part       = {1'b0, a[CHUNK-1:0]} + {1'b0, b_eff[CHUNK-1:0]}
               + {{CHUNK{1'b0}}, sub | cin};
    sum_d[0][CHUNK-1:0] = part[CHUNK-1:0];
    carry_d[0]          = part[CHUNK];

    // Stage k adds chunk k with the carry registered by stage k-1.
    for (int unsigned k = 1; k < STAGES; k++) begin
      valid_d[k] = valid_q[k-1];
      a_d[k]     = a_q[k-1];
      b_d[k]     = b_q[k-1];
      sum_d[k]   = sum_q[k-1];
      part       = {1'b0, a_q[k-1][k*CHUNK +: CHUNK]}
                 + {1'b0, b_q[k-1][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, carry_q[k-1]};
      sum_d[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
      carry_d[k]                 = part[CHUNK];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else if (adv) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];
  assign ovf       = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1])
                  && (sum_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_adder_pipe_addsub.sv
// Bench for adder_pipe_addsub: four instances (STAGES 1, 2, 4, 16) at WIDTH=16,
// directed vectors, backpressure and reset sequences, then randomized traffic against an arithmetic model.
module tb_adder_pipe_addsub;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [3:0]        iv, ir, ov, ordy, cin_v, sub_v, cout_v, ovf_v;
  logic [3:0][W-1:0] a_v, b_v, sum_v;

  int total = 0;
  int bad   = 0;

  adder_pipe_addsub #(.WIDTH(W), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_v[0]), .b(b_v[0]),
    .cin(cin_v[0]), .sub(sub_v[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]));
  adder_pipe_addsub #(.WIDTH(W), .STAGES(2)) u_s2 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_v[1]), .b(b_v[1]),
    .cin(cin_v[1]), .sub(sub_v[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]));
  adder_pipe_addsub #(.WIDTH(W), .STAGES(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a_v[2]), .b(b_v[2]),
    .cin(cin_v[2]), .sub(sub_v[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .sum(sum_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]));
  adder_pipe_addsub #(.WIDTH(W), .STAGES(16)) u_s16 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .a(a_v[3]), .b(b_v[3]),
    .cin(cin_v[3]), .sub(sub_v[3]), .out_valid(ov[3]), .out_ready(ordy[3]),
    .sum(sum_v[3]), .cout(cout_v[3]), .ovf(ovf_v[3]));

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[9];

  function automatic int stages_of(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      default: return 16;
    endcase
  endfunction

  // Reference: plain integer arithmetic, returns {cout, ovf, sum}.
  function automatic logic [17:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic c, input logic s);
    longint ux, uy, sx, sy, full, sres;
    logic   co, ov_l;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (s) begin
      full = ux - uy;
      co   = (ux >= uy);
      sres = sx - sy;
    end else begin
      full = ux + uy + longint'(c);
      co   = (full >= 65536);
      sres = sx + sy + longint'(c);
    end
    ov_l = (sres > 32767) || (sres < -32768);
    return {co, ov_l, full[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One isolated operation; measures latency and checks the result.
  task automatic run_single(input int i, input vec_t v, input string name);
    int lat;
    iv[i] = 1'b1; a_v[i] = v.a; b_v[i] = v.b; cin_v[i] = v.cin; sub_v[i] = v.sub;
    ordy[i] = 1'b1;
    #1;
    check({name, "_inready"}, 32'(ir[i]), 32'd1);
    step();
    iv[i] = 1'b0;
    a_v[i] = W'($urandom); b_v[i] = W'($urandom);
    cin_v[i] = 1'($urandom); sub_v[i] = 1'($urandom);
    lat = 1;
    while (!ov[i] && lat < 64) begin
      step();
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(stages_of(i)));
    check({name, "_result"}, {14'd0, cout_v[i], ovf_v[i], sum_v[i]},
          {14'd0, v.cout, v.ovf, v.sum});
    step();
  endtask

  task automatic run_random(input int i, input int n);
    logic [17:0] q[$];
    logic [17:0] exp;
    logic        prev_stall;
    logic [17:0] prev_out;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_out = '0;
    while (got < n && cyc < n * 10) begin
      iv[i]   = (($urandom % 10) < 7) && (sent < n);
      ordy[i] = ($urandom % 10) < 7;
      case ($urandom % 6)
        0:       a_v[i] = 16'hFFFF;
        1:       a_v[i] = 16'h8000;
        2:       a_v[i] = 16'h7FFF;
        default: a_v[i] = W'($urandom);
      endcase
      case ($urandom % 6)
        0:       b_v[i] = 16'h0001;
        1:       b_v[i] = 16'hFFFF;
        2:       b_v[i] = 16'h8000;
        default: b_v[i] = W'($urandom);
      endcase
      cin_v[i] = 1'($urandom);
      sub_v[i] = 1'($urandom);
      #1;
      check("rand_inready", 32'(ir[i]), 32'(!ov[i] || ordy[i]));
      if (prev_stall)
        check("rand_stall_hold", {13'd0, ov[i], cout_v[i], ovf_v[i], sum_v[i]},
              {13'd0, 1'b1, prev_out});
      if (iv[i] && ir[i]) begin
        q.push_back(model(a_v[i], b_v[i], cin_v[i], sub_v[i]));
        sent++;
      end
      if (ov[i] && ordy[i]) begin
        if (q.size() == 0) begin
          check("rand_unexpected_out", 32'd1, 32'd0);
        end else begin
          exp = q.pop_front();
          check("rand_result", {14'd0, cout_v[i], ovf_v[i], sum_v[i]}, {14'd0, exp});
        end
        got++;
      end
      prev_stall = ov[i] && !ordy[i];
      prev_out   = {cout_v[i], ovf_v[i], sum_v[i]};
      step();
      cyc++;
    end
    check("rand_count", 32'(got), 32'(n));
    iv[i] = 1'b0; ordy[i] = 1'b1;
    step();
  endtask

  initial begin
    int acc, got, cyc, seen;
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[8] = '{16'h0000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

    rst = 1'b1; iv = '0; ordy = '1; a_v = '0; b_v = '0; cin_v = '0; sub_v = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("reset_inready", 32'(ir[i]), 32'd1);
      check("reset_outputs", {13'd0, ov[i], cout_v[i], ovf_v[i], sum_v[i]}, 32'd0);
    end
    @(negedge clk);

    for (int i = 0; i < 4; i++)
      for (int v = 0; v < 9; v++)
        run_single(i, vecs[v], $sformatf("vec%0d_st%0d", v, stages_of(i)));

    // Backpressure: six ops a=b=k while the output is blocked.
    ordy[2] = 1'b0; acc = 0;
    for (int c = 0; c < 8; c++) begin
      iv[2] = 1'b1; a_v[2] = W'(acc); b_v[2] = W'(acc); cin_v[2] = 1'b0; sub_v[2] = 1'b0;
      #1;
      if (ir[2]) acc++;
      step();
    end
    #1;
    check("bp_accepted", 32'(acc), 32'd4);
    check("bp_inready_low", 32'(ir[2]), 32'd0);
    check("bp_head_held", {15'd0, ov[2], sum_v[2]}, {15'd0, 1'b1, 16'd0});
    @(negedge clk);
    got = 0; cyc = 0;
    while (got < 6 && cyc < 40) begin
      ordy[2] = 1'b1;
      iv[2] = (acc < 6); a_v[2] = W'(acc); b_v[2] = W'(acc);
      #1;
      check("bp_drain_valid", 32'(ov[2]), 32'd1);
      if (ov[2]) begin
        check("bp_drain_sum", 32'(sum_v[2]), 32'(2 * got));
        got++;
      end
      if (iv[2] && ir[2]) acc++;
      step();
      cyc++;
    end
    check("bp_drain_cycles", 32'(cyc), 32'd6);
    iv[2] = 1'b0;
    step();

    // Reset with three operations in flight.
    for (int k = 0; k < 3; k++) begin
      iv[2] = 1'b1; a_v[2] = W'(16'h0100 + k); b_v[2] = 16'h0001; cin_v[2] = 1'b0; sub_v[2] = 1'b0;
      step();
    end
    iv[2] = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rst_mid_outputs", {15'd0, ov[2], sum_v[2]}, 32'd0);
    check("rst_mid_inready", 32'(ir[2]), 32'd1);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (ov[2]) seen++;
    end
    check("rst_mid_no_ghosts", 32'(seen), 32'd0);
    run_single(2, '{16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0}, "post_rst");

    for (int i = 0; i < 4; i++)
      run_random(i, 2500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
